// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: owns the PC, issues one word fetch at a time and
// queues returned instructions with their PCs in a small FIFO feeding decode.
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] req_pc_r;
    logic [AW-1:0]   head_r;
    logic [AW-1:0]   tail_r;
    logic [AW:0]     count_r;
    logic [31:0]     data_mem_r [DEPTH];
    logic [XLEN-1:0] pc_mem_r   [DEPTH];

    logic req_fire_s;
    logic enq_s;
    logic deq_s;

    // Request is raised only when idle, not full, not redirecting and out of reset.
    always_comb begin
        if (rst && (state_r == ST_ISSUE) && (count_r != DEPTH_C) && !redirect_valid) begin
            imem_req_valid = 1'b1;
        end else begin
            imem_req_valid = 1'b0;
        end
    end

    assign req_fire_s    = imem_req_valid && imem_req_ready;
    assign enq_s         = (state_r == ST_WAIT) && imem_resp_valid && !redirect_valid;
    assign deq_s         = inst_ready && (count_r != {(AW+1){1'b0}}) && !redirect_valid;
    assign imem_req_addr = fetch_pc_r;
    assign inst_valid    = (count_r != {(AW+1){1'b0}});
    assign inst_data     = data_mem_r[head_r];
    assign inst_pc       = pc_mem_r[head_r];

    // Fetch FSM and PC; a redirect always wins and may leave a stale response to drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_ISSUE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= {XLEN{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
            case (state_r)
                ST_WAIT, ST_DROP: state_r <= imem_resp_valid ? ST_ISSUE : ST_DROP;
                default:          state_r <= ST_ISSUE;
            endcase
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    if (req_fire_s) begin
                        req_pc_r   <= fetch_pc_r;
                        fetch_pc_r <= fetch_pc_r + XLEN'(32'd4);
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DROP: begin
                    if (imem_resp_valid) begin
                        state_r <= ST_ISSUE;
                    end
                end
                default: state_r <= ST_ISSUE;
            endcase
        end
    end

    // Instruction FIFO storage and pointers; flushed wholesale on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= 32'h0;
                pc_mem_r[i]   <= {XLEN{1'b0}};
            end
        end else if (redirect_valid) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (enq_s) begin
                data_mem_r[tail_r] <= imem_resp_data;
                pc_mem_r[tail_r]   <= req_pc_r;
                tail_r             <= tail_r + AW'(1'b1);
            end
            if (deq_s) begin
                head_r <= head_r + AW'(1'b1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
